// File: rtl/stage_ex_md_pkg.sv
// stage_ex_md_pkg: shared pipeline register types, opcodes and helpers for the execute stage
package stage_ex_md_pkg;
  localparam int PIPE_XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY1
  } alu_fun_e;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
  typedef struct packed {
    logic                 valid;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] alu_op1;
    logic [PIPE_XLEN-1:0] alu_op2;
    alu_fun_e             alu_fun;
    logic                 md_en;
    logic [2:0]           func3;
    logic                 dmem_wr_en;
    logic                 dmem_rd_en;
    logic [PIPE_XLEN-1:0] dmem_wdata;
    logic                 reg_wr_en;
    logic [4:0]           rd;
    logic [1:0]           wb_sel;
  } id_ex_reg_t;
  typedef struct packed {
    logic                 valid;
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] alu_result;
    logic [2:0]           func3;
    logic                 dmem_wr_en;
    logic                 dmem_rd_en;
    logic [PIPE_XLEN-1:0] dmem_wdata;
    logic                 reg_wr_en;
    logic [4:0]           rd;
    logic [1:0]           wb_sel;
  } ex_ma_reg_t;
  function automatic logic md_op1_signed(input logic [2:0] f);
    return f != MD_MULHU && f != MD_DIVU && f != MD_REMU;
  endfunction
  function automatic logic md_op2_signed(input logic [2:0] f);
    return f == MD_MUL || f == MD_MULH || f == MD_DIV || f == MD_REM;
  endfunction
endpackage

// File: rtl/stage_ex_md_muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide resolving MD_BPC result bits per cycle
module muldiv_iter
  import stage_ex_md_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MD_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            squash,
  input  logic            stall,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / MD_BPC;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int W  = XLEN + MD_BPC;
  localparam int W2 = 2 * XLEN;
  md_state_e         state;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     p, p_n, prod;
  logic [XLEN-1:0]   b, mag1, mag2, div_r, div_q, quo, rem;
  logic [XLEN:0]     div_t;
  logic [W-1:0]      mul_t;
  logic [2:0]        f3;
  logic              s1, s2, sgn1, sgn2, div_zero, div_ovf, fast, div_ge;
  assign sgn1     = op1[XLEN-1] && md_op1_signed(func3);
  assign sgn2     = op2[XLEN-1] && md_op2_signed(func3);
  assign mag1     = sgn1 ? -op1 : op1;
  assign mag2     = sgn2 ? -op2 : op2;
  assign div_zero = func3[2] && op2 == '0;
  assign div_ovf  = func3[2] && !func3[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && &op2;
  assign fast     = div_zero || div_ovf;
  always_comb begin
    mul_t  = W'(p[W2-1:XLEN]) + W'(b) * W'(p[MD_BPC-1:0]);
    div_r  = p[W2-1:XLEN];
    div_q  = p[XLEN-1:0];
    div_t  = '0;
    div_ge = 1'b0;
    for (int i = 0; i < MD_BPC; i++) begin
      div_t  = {div_r, div_q[XLEN-1]};
      div_ge = div_t >= {1'b0, b};
      div_r  = div_ge ? XLEN'(div_t - {1'b0, b}) : div_t[XLEN-1:0];
      div_q  = {div_q[XLEN-2:0], div_ge};
    end
    p_n    = f3[2] ? {div_r, div_q} : W2'({mul_t, p[XLEN-1:0]} >> MD_BPC);
    prod   = (s1 ^ s2) ? -p : p;
    quo    = (s1 ^ s2) ? -p[XLEN-1:0] : p[XLEN-1:0];
    rem    = s1 ? -p[W2-1:XLEN] : p[W2-1:XLEN];
    result = !f3[2] ? (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[W2-1:XLEN]) : (f3[1] ? rem : quo);
  end
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      if (squash) state <= MD_IDLE;
      else if (state == MD_IDLE && start) state <= fast ? MD_DONE : MD_RUN;
      else if (state == MD_RUN && cnt == '0) state <= MD_DONE;
      else if (state == MD_DONE && !stall) state <= MD_IDLE;
      if (state == MD_IDLE && start) begin
        cnt <= CW'(N - 1);
        f3  <= func3;
        b   <= mag2;
        s1  <= sgn1 && !fast;
        s2  <= sgn2 && !fast;
        p   <= div_zero ? {op1, {XLEN{1'b1}}} : div_ovf ? {{XLEN{1'b0}}, op1} : {{XLEN{1'b0}}, mag1};
      end else if (state == MD_RUN) begin
        cnt <= cnt - 1'b1;
        p   <= p_n;
      end
    end
  end
  assign done = state == MD_DONE;
  assign busy = rst_ni && !squash && ((state == MD_IDLE && start) || state == MD_RUN || (done && stall));
endmodule

// File: rtl/stage_ex_md.sv
// stage_ex_md: execute stage with single-cycle ALU, iterative RV32M unit and the EX-MA register
module stage_ex_md
  import stage_ex_md_pkg::*;
#(
  parameter int XLEN   = PIPE_XLEN,
  parameter int MD_BPC = 1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       squash_i,
  input  logic       stall_i,
  input  id_ex_reg_t id_ex_i,
  output ex_ma_reg_t ex_ma_reg_o,
  output logic       ex_busy_o
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] a, b, alu_res, md_res;
  logic [SW-1:0]   sh;
  logic            md_done, bubble;
  ex_ma_reg_t      ex_ma_n;
  assign a  = id_ex_i.alu_op1;
  assign b  = id_ex_i.alu_op2;
  assign sh = b[SW-1:0];
  always_comb begin
    case (id_ex_i.alu_fun)
      ALU_SUB:   alu_res = a - b;
      ALU_SLL:   alu_res = a << sh;
      ALU_SLT:   alu_res = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:  alu_res = XLEN'(a < b);
      ALU_XOR:   alu_res = a ^ b;
      ALU_SRL:   alu_res = a >> sh;
      ALU_SRA:   alu_res = $signed(a) >>> sh;
      ALU_OR:    alu_res = a | b;
      ALU_AND:   alu_res = a & b;
      ALU_COPY1: alu_res = a;
      default:   alu_res = a + b;
    endcase
  end
  muldiv_iter #(.XLEN(XLEN), .MD_BPC(MD_BPC)) u_md (
    .clk    (clk),
    .rst_ni (rst_ni),
    .squash (squash_i),
    .stall  (stall_i),
    .start  (id_ex_i.valid && id_ex_i.md_en),
    .func3  (id_ex_i.func3),
    .op1    (a),
    .op2    (b),
    .busy   (ex_busy_o),
    .done   (md_done),
    .result (md_res)
  );
  assign bubble = squash_i || (id_ex_i.md_en && !md_done);
  always_comb begin
    ex_ma_n.valid      = id_ex_i.valid && !bubble;
    ex_ma_n.pc         = id_ex_i.pc;
    ex_ma_n.alu_result = id_ex_i.md_en ? md_res : alu_res;
    ex_ma_n.func3      = id_ex_i.func3;
    ex_ma_n.dmem_wr_en = id_ex_i.dmem_wr_en && !bubble;
    ex_ma_n.dmem_rd_en = id_ex_i.dmem_rd_en;
    ex_ma_n.dmem_wdata = id_ex_i.dmem_wdata;
    ex_ma_n.reg_wr_en  = id_ex_i.reg_wr_en && !bubble;
    ex_ma_n.rd         = id_ex_i.rd;
    ex_ma_n.wb_sel     = id_ex_i.wb_sel;
  end
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      ex_ma_reg_o.valid      <= 1'b0;
      ex_ma_reg_o.dmem_wr_en <= 1'b0;
      ex_ma_reg_o.reg_wr_en  <= 1'b0;
    end else if (!stall_i) begin
      ex_ma_reg_o <= ex_ma_n;
    end
  end
endmodule

// File: doc/stage_ex_md.md
# stage_ex_md

Parametrised execute stage for the 5-stage RISC-V pipeline, adding an iterative RV32M multiply/divide unit to the single-cycle ALU path. It sits between the ID-EX and EX-MA pipeline registers. Single-cycle ops pass through in one cycle. MUL/DIV ops occupy EX for several cycles while `ex_busy_o` holds the front end. The EX-MA register receives bubbles until the result is ready.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be even and ≥ 8.
- `MD_BPC`, 1: result bits resolved per iteration cycle; must divide `XLEN`. Define `N = XLEN/MD_BPC`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `squash_i`  in  1  hazard unit kills the instruction in EX; aborts any M-op in flight.
- `stall_i`  in  1  downstream stall; EX-MA register holds.
- `id_ex_i`  in  `id_ex_reg_t`  ID-EX register contents. Includes `valid`, `alu_op1/op2`, `alu_fun`, `md_en`, `func3`, memory and writeback fields.
- `ex_ma_reg_o`  out  `ex_ma_reg_t`  EX-MA pipeline register.
- `ex_busy_o`  out  1  EX holds a multi-cycle op. Hazard unit must stall IF/ID and keep `id_ex_i` stable while high.

## Operation
- Non-M instruction (`md_en=0`): ALU result and pass-through fields load into `ex_ma_n`.
- Squash: `squash_i` forces `valid=0` and `dmem_wr_en=0` in `ex_ma_n`.
- M-op FSM states: IDLE, RUN, DONE.
- IDLE → RUN: on `id_ex_i.valid && md_en && !squash_i`.
  - Latch operand magnitudes, sign flags and `func3`.
  - Load iteration counter with `N-1`.
- IDLE → DONE (fast path): on divide-by-zero or signed overflow (`-2^(XLEN-1) / -1`), skipping RUN.
- RUN: one iteration of shift-add (MUL*) or restoring division (DIV*/REM*) per cycle, `MD_BPC` bits each. Leave for DONE when the counter reaches 0.
- DONE: apply sign correction, then write result into `ex_ma_n.alu_result` with the `id_ex_i` pass-through fields. Go to IDLE when `!stall_i`.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Quotient sign = s1^s2; remainder sign = s1.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits of the 2·XLEN product.
- Special results:
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow: quotient = dividend, remainder 0.
- While in IDLE-start cycle or RUN, `ex_ma_n` is a bubble: `valid=0`, `dmem_wr_en=0`, `reg_wr_en=0`.
- `ex_busy_o` = `!squash_i && ((IDLE && start) || RUN || (DONE && stall_i))`.
- `squash_i` in any state: FSM goes to IDLE at the next edge, no result is written, and `ex_busy_o` is low in that cycle.
- `stall_i` during RUN: iteration continues. The EX-MA register holds. The result still appears only in DONE.

## Timing
- Reset (`rst_ni=0` at edge):
  - FSM → IDLE, counter → 0, `ex_busy_o=0`.
  - `ex_ma_reg_o.valid`, `.dmem_wr_en`, `.reg_wr_en` = 0; other fields don't-care.
  - Reset mid-RUN abandons the op.
- Single-cycle op: result in `ex_ma_reg_o` one edge after presentation.
- M-op presented in cycle 0: RUN cycles 1..N, DONE in cycle N+1. Result visible after the edge ending cycle N+1, giving latency N+2 (34 for defaults).
- Fast-path M-op: DONE in cycle 1, latency 2.
- Back-to-back M-ops: the second starts in the cycle after DONE is left, with no extra gap.
- `stall_i` has priority over EX-MA loading in every state.

## Structure
- Shared pipeline package owns:
  - `id_ex_reg_t` and `ex_ma_reg_t`; `id_ex_reg_t` gains `md_en`.
  - `md_op_e` (func3 encodings MUL..REMU).
  - FSM state enum.
- Sub-module `muldiv_iter`, parametrised by `XLEN` and `MD_BPC`, owns the FSM, counter, sign logic and special cases. The stage owns the ALU instance, muxing and the EX-MA register.

## Test plan
- ADD 5+7, no stall → next cycle `alu_result=12`, `valid=1`, `ex_busy_o` never high.
- MUL 7 × -3 → busy for 33 cycles, bubbles meanwhile; result 0xFFFFFFEB at latency 34. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All at latency 2.
- DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; MULHSU -1 × 2 → 0xFFFFFFFF.
- `squash_i` at RUN cycle 10 → busy low the same cycle, FSM IDLE, no valid result. Next ADD completes normally.
- `stall_i` held 3 cycles in DONE → busy stays high and the result appears once. `rst_ni=0` mid-RUN → all outputs at reset values next cycle.
